// File: rtl/approx_mult_if.sv
// approx_mult_if: operand/result valid-ready bus for the pipelined approximate multiplier
interface approx_mult_if #(parameter int WIDTH = 8);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_exact;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_y;
   logic [15:0]        skip_cnt;
   modport master (output in_valid, in_a, in_b, in_exact, out_ready,
                   input in_ready, out_valid, out_y, skip_cnt);
   modport slave (input in_valid, in_a, in_b, in_exact, out_ready,
                  output in_ready, out_valid, out_y, skip_cnt);
endinterface

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: two-stage valid/ready multiplier with truncated LSB columns and runtime exact mode
module approx_mult_pipe #(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 4,
   parameter int COMP        = 1,
   parameter int ADDER_SEL   = 0
) (
   input logic clk,
   input logic rst,
   approx_mult_if.slave bus
);
   localparam int N = 2 * WIDTH;
   localparam int H = WIDTH / 2;
   localparam int SH = (APPROX_COLS > 0) ? APPROX_COLS - 1 : 0;
   localparam logic [N-1:0] COMP_V = (COMP != 0 && APPROX_COLS > 0) ? (N'(1) << SH) : '0;

   function automatic logic [N-1:0] add_rca(input logic [N-1:0] x, input logic [N-1:0] z);
      logic [N-1:0] r;
      logic c;
      r = '0;
      c = 1'b0;
      for (int k = 0; k < N; k++) begin
         r[k] = x[k] ^ z[k] ^ c;
         c = (x[k] & z[k]) | (c & (x[k] ^ z[k]));
      end
      return r;
   endfunction

   function automatic logic [N-1:0] add_skip(input logic [N-1:0] x, input logic [N-1:0] z);
      logic [N-1:0] r;
      logic c, cin, p;
      r = '0;
      c = 1'b0;
      for (int g = 0; g < N; g += 4) begin
         cin = c;
         p = 1'b1;
         for (int k = g; k < g + 4 && k < N; k++) begin
            r[k] = x[k] ^ z[k] ^ c;
            p = p & (x[k] ^ z[k]);
            c = (x[k] & z[k]) | (c & (x[k] ^ z[k]));
         end
         c = p ? cin : c;
      end
      return r;
   endfunction

   function automatic logic [N-1:0] add_csel(input logic [N-1:0] x, input logic [N-1:0] z);
      logic [N-1:0] r, s0, s1;
      logic c, c0, c1;
      r = '0;
      s0 = '0;
      s1 = '0;
      c = 1'b0;
      for (int g = 0; g < N; g += 4) begin
         c0 = 1'b0;
         c1 = 1'b1;
         for (int k = g; k < g + 4 && k < N; k++) begin
            s0[k] = x[k] ^ z[k] ^ c0;
            c0 = (x[k] & z[k]) | (c0 & (x[k] ^ z[k]));
            s1[k] = x[k] ^ z[k] ^ c1;
            c1 = (x[k] & z[k]) | (c1 & (x[k] ^ z[k]));
         end
         for (int k = g; k < g + 4 && k < N; k++) r[k] = c ? s1[k] : s0[k];
         c = c ? c1 : c0;
      end
      return r;
   endfunction

   // Conditional sum: each group keeps both sum/carry outcomes and groups merge pairwise at doubling sizes.
   function automatic logic [N-1:0] add_cond(input logic [N-1:0] x, input logic [N-1:0] z);
      logic [N-1:0] s0, s1, c0, c1;
      logic t0, t1, n0, n1;
      s0 = x ^ z;
      s1 = ~(x ^ z);
      c0 = x & z;
      c1 = x | z;
      for (int g = 1; g < N; g = g * 2) begin
         for (int lo = 0; lo + g < N; lo += 2 * g) begin
            for (int k = lo + g; k < lo + 2 * g && k < N; k++) begin
               t0 = s0[k];
               t1 = s1[k];
               s0[k] = c0[lo] ? t1 : t0;
               s1[k] = c1[lo] ? t1 : t0;
            end
            n0 = c0[lo] ? c1[lo+g] : c0[lo+g];
            n1 = c1[lo] ? c1[lo+g] : c0[lo+g];
            c0[lo] = n0;
            c1[lo] = n1;
         end
      end
      return s0;
   endfunction

   logic             s1_valid, s1_exact, s1_zero, s2_valid, ready2, accept, zero_in;
   logic [WIDTH-1:0] s1_a, s1_b, arr_a, arr_b;
   logic [N-1:0]     pp, row_lo, row_hi, add_in, comp, sum, y;

   assign ready2        = ~s2_valid | bus.out_ready;
   assign bus.in_ready  = ~s1_valid | ready2;
   assign bus.out_valid = s2_valid;
   assign accept        = bus.in_valid & bus.in_ready;
   assign zero_in       = (bus.in_a == '0) || (bus.in_b == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         s1_exact     <= 1'b0;
         s1_zero      <= 1'b0;
         s1_a         <= '0;
         s1_b         <= '0;
         s2_valid     <= 1'b0;
         bus.out_y    <= '0;
         bus.skip_cnt <= '0;
      end else begin
         if (bus.in_ready) s1_valid <= bus.in_valid;
         if (accept) begin
            s1_exact <= bus.in_exact;
            s1_zero  <= zero_in;
         end
         // Zero ops leave the operand registers untouched so the array sees no toggles.
         if (accept && !zero_in) begin
            s1_a <= bus.in_a;
            s1_b <= bus.in_b;
         end
         if (accept && zero_in && bus.skip_cnt != 16'hFFFF) bus.skip_cnt <= bus.skip_cnt + 16'd1;
         if (ready2) s2_valid <= s1_valid;
         if (s1_valid && ready2) bus.out_y <= y;
      end
   end

   assign arr_a  = s1_zero ? '0 : s1_a;
   assign arr_b  = s1_zero ? '0 : s1_b;
   assign comp   = (s1_exact || s1_zero) ? '0 : COMP_V;
   assign add_in = row_hi + comp;

   always_comb begin
      row_lo = '0;
      row_hi = '0;
      pp = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pp = '0;
         for (int j = 0; j < WIDTH; j++) pp[i+j] = arr_a[i] & arr_b[j] & (s1_exact | (i + j >= APPROX_COLS));
         if (i < H) row_lo = row_lo + pp;
         else row_hi = row_hi + pp;
      end
   end

   always_comb begin
      sum = ADDER_SEL == 1 ? add_skip(row_lo, add_in) :
            ADDER_SEL == 2 ? add_csel(row_lo, add_in) :
            ADDER_SEL == 3 ? add_cond(row_lo, add_in) : add_rca(row_lo, add_in);
      y = s1_zero ? '0 : sum;
   end
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: directed + random scoreboard bench over all four adder styles
module tb_approx_mult_pipe;
   localparam int W  = 8;
   localparam int AC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_exact = 1'b0, out_ready = 1'b1;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic last_acc = 1'b0;
   logic [2*W-1:0] q[$];
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   approx_mult_if #(.WIDTH(W)) b0 (), b1 (), b2 (), b3 ();
   assign b0.in_valid = in_valid;  assign b0.in_a = in_a;  assign b0.in_b = in_b;  assign b0.in_exact = in_exact;  assign b0.out_ready = out_ready;
   assign b1.in_valid = in_valid;  assign b1.in_a = in_a;  assign b1.in_b = in_b;  assign b1.in_exact = in_exact;  assign b1.out_ready = out_ready;
   assign b2.in_valid = in_valid;  assign b2.in_a = in_a;  assign b2.in_b = in_b;  assign b2.in_exact = in_exact;  assign b2.out_ready = out_ready;
   assign b3.in_valid = in_valid;  assign b3.in_a = in_a;  assign b3.in_b = in_b;  assign b3.in_exact = in_exact;  assign b3.out_ready = out_ready;

   approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC), .COMP(1), .ADDER_SEL(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
   approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC), .COMP(1), .ADDER_SEL(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
   approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC), .COMP(1), .ADDER_SEL(2)) d2 (.clk(clk), .rst(rst), .bus(b2));
   approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC), .COMP(1), .ADDER_SEL(3)) d3 (.clk(clk), .rst(rst), .bus(b3));

   // Reference: full product minus the dropped low columns (row-wise remainder), plus 2^(AC-1).
   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ex);
      int p;
      p = int'(a) * int'(b);
      if (a == 0 || b == 0) return '0;
      if (ex) return p[2*W-1:0];
      for (int i = 0; i < AC; i++) if (a[i]) p -= (int'(b) % (1 << (AC - i))) << i;
      p += 1 << (AC - 1);
      return p[2*W-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_out();
      logic [2*W-1:0] e;
      checks++;
      assert (q.size() != 0) else begin
         failures++;
         $error("FAIL spurious_out got=out_valid exp=empty_scoreboard");
      end
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("out_y_rca", 32'(b0.out_y), 32'(e));
         chk("out_y_skip", 32'(b1.out_y), 32'(e));
         chk("out_y_csel", 32'(b2.out_y), 32'(e));
         chk("out_y_cond", 32'(b3.out_y), 32'(e));
      end
   endtask

   task automatic step();
      logic acc, cons;
      #1;
      acc = in_valid && b0.in_ready;
      cons = b0.out_valid && out_ready;
      if (cons) check_out();
      if (acc) q.push_back(model(in_a, in_b, in_exact));
      last_acc = acc;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ex);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_exact = ex;
      last_acc = 1'b0;
      for (int t = 0; t < 20 && !last_acc; t++) step();
      chk("accept", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int t = 0; t < 50 && q.size() != 0; t++) step();
      chk("drain", q.size(), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
      chk("rst_out_y", 32'(b0.out_y), 32'd0);
      chk("rst_skip", 32'(b0.skip_cnt), 32'd0);
      chk("rst_in_ready", 32'(b0.in_ready), 32'd1);

      send(8'hFF, 8'hFF, 1'b1);
      chk("lat_k", 32'(b0.out_valid), 32'd0);
      step();
      chk("lat_k1", 32'(b0.out_valid), 32'd1);
      chk("exact_ff", 32'(b0.out_y), 32'hFE01);
      drain();
      send(8'hFF, 8'hFF, 1'b0);
      step();
      chk("approx_ff", 32'(b0.out_y), 32'hFDD8);
      drain();

      send(8'd3, 8'd5, 1'b0);
      step();
      chk("trunc_approx", 32'(b0.out_y), 32'h0008);
      drain();
      send(8'd3, 8'd5, 1'b1);
      step();
      chk("trunc_exact", 32'(b0.out_y), 32'h000F);
      drain();

      send(8'h00, 8'h7F, 1'b0);
      send(8'h12, 8'h00, 1'b0);
      drain();
      chk("skip_cnt2", 32'(b0.skip_cnt), 32'd2);

      send(8'h21, 8'h43, 1'b0);
      send(8'h65, 8'h87, 1'b1);
      chk("mid_out_valid", 32'(b0.out_valid), 32'd1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_out_valid", 32'(b0.out_valid), 32'd0);
      chk("mid_rst_out_y", 32'(b0.out_y), 32'd0);
      chk("mid_rst_skip", 32'(b0.skip_cnt), 32'd0);
      rst = 1'b0;
      q.delete();
      chk("mid_rst_in_ready", 32'(b0.in_ready), 32'd1);
      repeat (3) begin
         step();
         chk("lost_ops", 32'(b0.out_valid), 32'd0);
      end

      out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0);
      send(8'h33, 8'h44, 1'b1);
      in_valid = 1'b1;
      in_a = 8'h55;
      in_b = 8'h66;
      in_exact = 1'b0;
      #1;
      chk("in_ready_full", 32'(b0.in_ready), 32'd0);
      step();
      step();
      chk("stall_no_acc", 32'(last_acc), 32'd0);
      chk("stall_y", 32'(b0.out_y), 32'(model(8'h11, 8'h22, 1'b0)));
      out_ready = 1'b1;
      chk("bb_v1", 32'(b0.out_valid), 32'd1);
      step();
      chk("bb_acc3", 32'(last_acc), 32'd1);
      in_a = 8'h77;
      in_b = 8'h88;
      in_exact = 1'b1;
      chk("bb_v2", 32'(b0.out_valid), 32'd1);
      step();
      chk("bb_acc4", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
      chk("bb_v3", 32'(b0.out_valid), 32'd1);
      step();
      chk("bb_v4", 32'(b0.out_valid), 32'd1);
      step();
      chk("bb_done", q.size(), 32'd0);

      for (int n = 0; n < 200; n++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid = 1'b1;
         in_a = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
         in_b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
         in_exact = 1'($urandom);
         last_acc = 1'b0;
         for (int t = 0; t < 20 && !last_acc; t++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
         end
         chk("rand_accept", 32'(last_acc), 32'd1);
      end
      in_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit combinational approximate multiplier.
- Multiplies WIDTH-bit unsigned operands, truncating the APPROX_COLS least-significant partial-product columns, with optional compensation and a runtime exact mode.
- Valid/ready handshake on input and output; two register stages.
- Stage registers load only on handshake. Zero operands skip the array, so idle or zero ops do not toggle datapath registers; this is the clock-gating hook for power work.

Parameters:
- WIDTH, 8, operand width in bits (legal 4..16).
- APPROX_COLS, 4, number of LSB partial-product columns dropped in approx mode (legal 0..WIDTH).
- COMP, 1, 1 = add constant 2^(APPROX_COLS-1) to approx results (ignored when APPROX_COLS=0).
- ADDER_SEL, 0, final adder style: 0 RCA, 1 CSA, 2 CSLA, 3 COSA. All styles must produce bit-identical results.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_exact  input  1  1 = exact product for this operation; sampled with the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_y  output  2*WIDTH  product.
- skip_cnt  output  16  saturating count of zero-operand operations accepted since reset.

Behaviour:
- Reset, synchronous with rst=1 at a rising edge:
  - out_valid=0, out_y=0, skip_cnt=0.
  - Both stage valid flags clear; any in-flight operations are discarded.
  - in_ready is 1 in the first cycle after reset deassert.
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
- Pipeline:
  - S1 registers a, b, exact and a zero flag (a==0 | b==0).
  - S2 registers out_y.
  - ready2 = ~s2_valid | out_ready; in_ready = ~s1_valid | ready2 (combinational, no skid buffer).
  - S2 loads when s1_valid & ready2. S1 loads on input accept.
- Latency: accepted at edge k, so out_valid=1 after edge k+1 with an unstalled pipeline.
- Throughput: 1 op/cycle.
- Stall:
  - out_valid & ~out_ready holds out_y and all stage contents stable.
  - No stage register may change unless it is loading.
  - in_ready drops only when both stages are full and out_ready=0.
- Arithmetic:
  - P = sum of a_i·b_j·2^(i+j).
  - Exact mode, or APPROX_COLS=0: out_y = a·b.
  - Approx mode: only terms with i+j ≥ APPROX_COLS are summed. If COMP=1, add 2^(APPROX_COLS-1).
  - Result is modulo 2^(2*WIDTH).
- Zero skip:
  - A zero flag forces out_y=0, with no compensation added.
  - The array input is held at 0 (operand isolation).
  - skip_cnt increments on accept of a zero-operand op and saturates at 0xFFFF.
- Simultaneous events:
  - Output consume and input accept in the same cycle: both take effect, with no bubble.
  - rst overrides every handshake.
- Ordering: results leave in acceptance order; none dropped or duplicated.

Test Plan (WIDTH=8, APPROX_COLS=4, COMP=1, out_ready=1 unless stated):
1. Reset: assert rst 2 cycles mid-stream with 2 ops in flight -> out_valid=0, out_y=0, skip_cnt=0, in-flight ops lost, in_ready=1 next cycle.
2. Exact/approx on A=0xFF, B=0xFF:
   - in_exact=1 -> out_y=0xFE01, 2 cycles after accept.
   - in_exact=0 -> out_y=0xFDD8 (0xFE01 - 0x31 + 0x8).
3. Fully truncated: A=3, B=5, approx -> out_y=0x0008. Same operands with in_exact=1 -> out_y=0x000F.
4. Zero skip: A=0x00, B=0x7F, approx, then A=0x12, B=0x00 -> out_y=0x0000 both times, skip_cnt=2.
5. Backpressure: stream 4 ops with out_ready=0 for 3 cycles:
   - in_ready=0 once 2 are held.
   - out_y stable while stalled.
   - After release, all 4 results arrive in order, back-to-back.
6. Adder styles: instantiate ADDER_SEL=0..3 in parallel, run 200 random ops with random in_exact -> all out_y identical and equal to the reference model.
